// File: rtl/array_bist_ctrl.sv
// March-style BIST sequencer for a registered-read memory: writes P(a), reads it back,
// then repeats with ~P(a), counting mismatches and capturing the first failing location.
module array_bist_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  parameter int ADDR  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] mem_write_data,
  output logic [ADDR-1:0]  mem_write_addr,
  output logic             mem_write_en,
  output logic [ADDR-1:0]  mem_read_addr,
  input  logic [WIDTH-1:0] mem_read_data,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic [ADDR-1:0]  first_fail_addr,
  output logic             first_fail_phase
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR0,
    S_RD0,
    S_WR1,
    S_RD1,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [ADDR-1:0] A_LAST = ADDR'(DEPTH - 1);

  state_t           state_q, state_d;
  logic [ADDR-1:0]  a_q, a_d;

  logic [WIDTH-1:0] mem_write_data_q;
  logic [ADDR-1:0]  mem_write_addr_q;
  logic             mem_write_en_q;
  logic [ADDR-1:0]  mem_read_addr_q;
  logic             busy_q;
  logic             done_q;
  logic [7:0]       err_q;
  logic [ADDR-1:0]  ffa_q;
  logic             ffp_q;

  logic             cmp_valid_q;
  logic [WIDTH-1:0] cmp_exp_q;
  logic [ADDR-1:0]  cmp_addr_q;
  logic             cmp_phase_q;

  logic             start_accept;
  logic             wr_d, rd_d, mismatch;

  function automatic logic [WIDTH-1:0] pat_f(input logic [ADDR-1:0] addr, input logic inv);
    logic [ADDR+7:0] prod;
    prod = (ADDR+8)'(addr) * (ADDR+8)'(8'h11);
    pat_f = inv ? ~WIDTH'(prod) : WIDTH'(prod);
  endfunction

  assign start_accept = start && (state_q == S_IDLE || state_q == S_DONE);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_WR0;
          a_d     = '0;
        end
      end
      S_WR0, S_RD0, S_WR1, S_RD1: begin
        if (a_q == A_LAST) begin
          a_d = '0;
          case (state_q)
            S_WR0:   state_d = S_RD0;
            S_RD0:   state_d = S_WR1;
            S_WR1:   state_d = S_RD1;
            default: state_d = S_DRAIN;
          endcase
        end else begin
          a_d = a_q + ADDR'(1);
        end
      end
      S_DRAIN: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Memory-facing outputs are registered from the next state so they line up with state_q.
  assign wr_d     = (state_d == S_WR0) || (state_d == S_WR1);
  assign rd_d     = (state_d == S_RD0) || (state_d == S_RD1);
  assign mismatch = cmp_valid_q && (mem_read_data != cmp_exp_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= S_IDLE;
      a_q              <= '0;
      mem_write_data_q <= '0;
      mem_write_addr_q <= '0;
      mem_write_en_q   <= 1'b0;
      mem_read_addr_q  <= '0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      err_q            <= 8'd0;
      ffa_q            <= '0;
      ffp_q            <= 1'b0;
      cmp_valid_q      <= 1'b0;
      cmp_exp_q        <= '0;
      cmp_addr_q       <= '0;
      cmp_phase_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      a_q            <= a_d;
      busy_q         <= (state_d inside {S_WR0, S_RD0, S_WR1, S_RD1, S_DRAIN});
      done_q         <= (state_d == S_DONE);
      mem_write_en_q <= wr_d;
      if (wr_d) begin
        mem_write_addr_q <= a_d;
        mem_write_data_q <= pat_f(a_d, state_d == S_WR1);
      end
      if (rd_d) begin
        mem_read_addr_q <= a_d;
      end

      // Read data returns one cycle after the address, so the expectation is staged here.
      cmp_valid_q <= (state_q == S_RD0) || (state_q == S_RD1);
      cmp_exp_q   <= pat_f(a_q, state_q == S_RD1);
      cmp_addr_q  <= a_q;
      cmp_phase_q <= (state_q == S_RD1);

      if (start_accept) begin
        err_q <= 8'd0;
        ffa_q <= '0;
        ffp_q <= 1'b0;
      end else if (mismatch) begin
        if (err_q != 8'hFF) begin
          err_q <= err_q + 8'd1;
        end
        if (err_q == 8'd0) begin
          ffa_q <= cmp_addr_q;
          ffp_q <= cmp_phase_q;
        end
      end
    end
  end

  assign mem_write_data   = mem_write_data_q;
  assign mem_write_addr   = mem_write_addr_q;
  assign mem_write_en     = mem_write_en_q;
  assign mem_read_addr    = mem_read_addr_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = done_q && (err_q == 8'd0);
  assign err_count        = err_q;
  assign first_fail_addr  = ffa_q;
  assign first_fail_phase = ffp_q;

endmodule

// File: tb/tb_array_bist_ctrl.sv
// Bench for array_bist_ctrl: registered-read memory with injectable read faults, a
// cycle-indexed model of the run checked every negedge, and directed literal checks.
module tb_array_bist_ctrl;

  localparam int D = 8;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] mem_write_data;
  logic [2:0] mem_write_addr;
  logic       mem_write_en;
  logic [2:0] mem_read_addr;
  logic [7:0] mem_read_data;
  logic       busy, done, pass;
  logic [7:0] err_count;
  logic [2:0] first_fail_addr;
  logic       first_fail_phase;

  array_bist_ctrl #(.WIDTH(8), .DEPTH(D), .ADDR(3)) dut (
    .clk(clk), .rst(rst), .start(start),
    .mem_write_data(mem_write_data), .mem_write_addr(mem_write_addr),
    .mem_write_en(mem_write_en), .mem_read_addr(mem_read_addr),
    .mem_read_data(mem_read_data), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_fail_addr(first_fail_addr),
    .first_fail_phase(first_fail_phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] pat(input int a, input bit inv);
    logic [7:0] p;
    p = 8'(a * 17);
    return inv ? ~p : p;
  endfunction

  function automatic logic [7:0] flt(input logic [7:0] v, input int mode);
    if (mode == 1) return v & 8'hFE;
    if (mode == 2) return 8'h00;
    return v;
  endfunction

  // ---------------- memory with registered read and fault injection
  logic [7:0] mem [D];
  logic [7:0] rd_raw;
  logic [7:0] wlog [$];
  int         fault_mode = 0;

  always @(posedge clk) begin
    if (mem_write_en) begin
      mem[mem_write_addr] <= mem_write_data;
      wlog.push_back(mem_write_data);
    end
    rd_raw <= mem[mem_read_addr];
  end

  assign mem_read_data = flt(rd_raw, fault_mode);

  // ---------------- model: everything follows from cycles elapsed since the accepted start
  bit m_started;
  int m_c;
  int m_rd_prev;
  int m_mode;

  function automatic int exp_rd(input bit s, input int c, input int prev);
    if (!s) return prev;
    if (c < 4*D && ((c / D) % 2) == 1) return c % D;
    if (c >= D) return D - 1;
    return prev;
  endfunction

  // Reads issued at cycles <= c-2 have had their result folded into err_count.
  function automatic int err_at(input int c, input int mode, output int ffa, output int ffp);
    int n;
    int a;
    bit ph;
    logic [7:0] e;
    n = 0; ffa = 0; ffp = 0;
    for (int t = 0; t <= c - 2 && t < 4*D; t++) begin
      if (((t / D) % 2) == 1) begin
        a  = t % D;
        ph = (t / D) == 3;
        e  = pat(a, ph);
        if (flt(e, mode) != e) begin
          if (n == 0) begin ffa = a; ffp = int'(ph); end
          n++;
        end
      end
    end
    return (n > 255) ? 255 : n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_started <= 1'b0;
      m_c       <= 0;
      m_rd_prev <= 0;
      m_mode    <= 0;
    end else if (start && !(m_started && m_c <= 4*D)) begin
      m_rd_prev <= exp_rd(m_started, m_c, m_rd_prev);
      m_started <= 1'b1;
      m_c       <= 0;
      m_mode    <= fault_mode;
    end else if (m_started && m_c < 4*D + 1) begin
      m_c <= m_c + 1;
    end
  end

  always @(negedge clk) begin : model_cmp
    int  e_err, e_ffa, e_ffp;
    bit  e_busy, e_done, e_we;
    e_busy = m_started && m_c <= 4*D;
    e_done = m_started && m_c >= 4*D + 1;
    e_we   = m_started && m_c < 4*D && ((m_c / D) % 2) == 0;
    if (m_started) e_err = err_at(m_c, m_mode, e_ffa, e_ffp);
    else begin e_err = 0; e_ffa = 0; e_ffp = 0; end
    chk("m_busy", 32'(busy), 32'(e_busy));
    chk("m_done", 32'(done), 32'(e_done));
    chk("m_pass", 32'(pass), 32'(e_done && e_err == 0));
    chk("m_wr_en", 32'(mem_write_en), 32'(e_we));
    if (e_we) begin
      chk("m_wr_addr", 32'(mem_write_addr), 32'(m_c % D));
      chk("m_wr_data", 32'(mem_write_data), 32'(pat(m_c % D, (m_c / D) == 2)));
    end
    chk("m_rd_addr", 32'(mem_read_addr), 32'(exp_rd(m_started, m_c, m_rd_prev)));
    chk("m_err", 32'(err_count), 32'(e_err));
    chk("m_ffa", 32'(first_fail_addr), 32'(e_ffa));
    chk("m_ffp", 32'(first_fail_phase), 32'(e_ffp));
  end

  // ---------------- directed runs with literal expectations
  logic [7:0] exp_w [16];

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic run(input int mode, input int restart_at, input int e_err,
                     input int e_pass, input int e_ffa, input int e_ffp, input bit chk_w);
    int cyc;
    bit seen;
    fault_mode = mode;
    wlog.delete();
    pulse_start();
    chk("clr_done", 32'(done), 0);
    chk("clr_err", 32'(err_count), 0);
    chk("clr_ffa", 32'(first_fail_addr), 0);
    chk("run_busy", 32'(busy), 1);
    cyc = 0; seen = 0;
    while (!seen && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      start = (cyc == restart_at);
      if (done) seen = 1;
    end
    start = 1'b0;
    chk("done_latency", 32'(cyc), 33);
    chk("final_err", 32'(err_count), 32'(e_err));
    chk("final_pass", 32'(pass), 32'(e_pass));
    chk("final_ffa", 32'(first_fail_addr), 32'(e_ffa));
    chk("final_ffp", 32'(first_fail_phase), 32'(e_ffp));
    if (chk_w) begin
      chk("wlog_size", 32'(wlog.size()), 16);
      for (int i = 0; i < 16 && i < wlog.size(); i++) chk("wlog_data", 32'(wlog[i]), 32'(exp_w[i]));
    end
    $display("run mode=%0d restart=%0d: cycles=%0d err=%0d pass=%0b ffa=%0d ffp=%0b",
             mode, restart_at, cyc, err_count, pass, first_fail_addr, first_fail_phase);
  endtask

  initial begin
    exp_w = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77,
              8'hFF, 8'hEE, 8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h99, 8'h88};
    rst = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pass", 32'(pass), 0);
    chk("rst_err", 32'(err_count), 0);
    chk("rst_we", 32'(mem_write_en), 0);
    chk("rst_waddr", 32'(mem_write_addr), 0);
    chk("rst_wdata", 32'(mem_write_data), 0);
    chk("rst_raddr", 32'(mem_read_addr), 0);
    rst = 1'b0;
    $display("reset released");

    run(0, -1, 0, 1, 0, 0, 1'b1);   // healthy memory
    run(1, -1, 8, 0, 1, 0, 1'b1);   // bit0 stuck at 0
    run(0, -1, 0, 1, 0, 0, 1'b0);   // restart from DONE after a failing run
    run(2, -1, 15, 0, 1, 0, 1'b0);  // all reads return 0x00
    run(0, 10, 0, 1, 0, 0, 1'b0);   // second start mid-run is ignored

    // reset in the middle of RD0, checked before any further clock edge
    fault_mode = 1;
    pulse_start();
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_we", 32'(mem_write_en), 0);
    chk("midrst_err", 32'(err_count), 0);
    chk("midrst_done", 32'(done), 0);
    $display("reset asserted mid-run: busy=%0b we=%0b err=%0d", busy, mem_write_en, err_count);
    @(posedge clk); #1 rst = 1'b0;
    run(0, -1, 0, 1, 0, 0, 1'b1);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
